vtx_proj_fxp: RTL

Parametrised, handshaked perspective-projection unit for the 3D raster pipeline. Accepts one camera-space vertex (x, y, z) in signed fixed point and returns screen coordinates x_s = FOCAL·x/z + CX, y_s = FOCAL·y/z + CY. Supports ready/valid backpressure, saturation and optional near-plane clipping. It sits between the vertex transform stage and triangle setup, and replaces the fixed float32 single-shot projector with a configurable-width pipeline stage.

---
 rtl/proj_pkg.sv | 45 ++++
 rtl/fxp_div_seq.sv | 70 +++++++
 rtl/vtx_proj_fxp.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/proj_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proj_pkg
// Purpose  : Shared types and helpers for the vertex projection unit.
// Revision : 1.0
// ============================================================================
package proj_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 16;
    localparam int DEF_FW    = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_DIV_X = 3'd2,
        S_DIV_Y = 3'd3,
        S_DONE  = 3'd4
    } proj_state_e;

    // Signed add clamped to a w-bit two's complement range (w <= 63).
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        w
    );
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = {a[63], a} + {b[63], b};
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = ~hi;
        if (s > hi)      return hi[63:0];
        else if (s < lo) return lo[63:0];
        else             return s[63:0];
    endfunction

    function automatic logic signed [63:0] to_fxp(input int v, input int unsigned f);
        logic signed [63:0] t;
        t = 64'(v);
        return t <<< f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : fxp_div_seq
// Purpose  : Restoring unsigned divider, one quotient bit per cycle, NW cycles.
// Revision : 1.0
// ============================================================================
module fxp_div_seq #(
    parameter int NW = 56
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          i_start,
    input  logic [NW-1:0] i_dividend,
    input  logic [NW-1:0] i_divisor,
    output logic          o_busy,
    output logic          o_done,
    output logic [NW-1:0] o_quotient
);
    localparam int CW = $clog2(NW);

    logic [NW-1:0] r_rem, r_quo, r_div;
    logic [CW-1:0] r_cnt;
    logic          r_busy;

    logic [NW-1:0] w_rem_in, w_quo_in, w_div_in, w_rem_nx, w_quo_nx;
    logic [NW:0]   w_trial;
    logic          w_ge;

    // The start edge already performs the first iteration, so the last
    // quotient bit lands exactly NW edges after start.
    always_comb begin
        w_rem_in = i_start ? '0 : r_rem;
        w_quo_in = i_start ? i_dividend : r_quo;
        w_div_in = i_start ? i_divisor : r_div;
        w_trial  = {w_rem_in, w_quo_in[NW-1]};
        w_ge     = (w_trial >= {1'b0, w_div_in});
        w_rem_nx = w_ge ? NW'(w_trial - {1'b0, w_div_in}) : w_trial[NW-1:0];
        w_quo_nx = {w_quo_in[NW-2:0], w_ge};
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= w_rem_nx;
            r_quo  <= w_quo_nx;
            r_div  <= i_divisor;
            r_cnt  <= CW'(NW - 1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt != '0) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy     = r_busy && (r_cnt != '0);
    assign o_done     = r_busy && (r_cnt == '0);
    assign o_quotient = r_quo;

endmodule
`default_nettype wire

// File: rtl/vtx_proj_fxp.sv
`default_nettype none
// ============================================================================
// Module   : vtx_proj_fxp
// Purpose  : Handshaked fixed-point perspective projection (x,y,z -> x_s,y_s).
//            Define PROJ_NEAR_CLIP_EN to enable near-plane rejection.
// Revision : 1.0
// ============================================================================
module vtx_proj_fxp
    import proj_pkg::*;
#(
    parameter int                       WIDTH = DEF_WIDTH,
    parameter int                       FRAC  = DEF_FRAC,
    parameter int                       FW    = DEF_FW,
    parameter logic [FW-1:0]            FOCAL = FW'(64),
    parameter int                       CX    = 320,
    parameter int                       CY    = 240,
    parameter logic signed [WIDTH-1:0]  NEAR  = 'h1000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [2:0][WIDTH-1:0] coor_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [1:0][WIDTH-1:0] coor_out,
    output logic                  clip_out,
    output logic                  valid_out,
    input  logic                  ready_in
);
    localparam int NW = WIDTH + FRAC + FW;
    localparam logic signed [63:0] c_off_x = 64'(CX) <<< FRAC;
    localparam logic signed [63:0] c_off_y = 64'(CY) <<< FRAC;

    proj_state_e              r_state, w_next;
    logic [WIDTH-1:0]         r_x, r_y, r_z, r_az;
    logic [WIDTH-1:0]         w_ax, w_ay, w_az;
    logic [NW-1:0]            w_num_x, w_num_y, r_num_x, r_num_y;
    logic                     r_sx, r_sy;
    logic [1:0][WIDTH-1:0]    r_coor;
    logic                     r_valid;
    logic                     w_clip, w_start, w_step_done, w_in_x, w_neg, w_nz;
    logic                     w_div_busy, w_div_done;
    logic [NW-1:0]            w_dividend, w_divisor, w_quo;
    logic signed [63:0]       w_qmag, w_qs;
    logic [WIDTH-1:0]         w_res;

    always_comb begin
        w_ax    = r_x[WIDTH-1] ? (~r_x + 1'b1) : r_x;
        w_ay    = r_y[WIDTH-1] ? (~r_y + 1'b1) : r_y;
        w_az    = r_z[WIDTH-1] ? (~r_z + 1'b1) : r_z;
        w_num_x = (NW'(w_ax) * NW'(FOCAL)) << FRAC;
        w_num_y = (NW'(w_ay) * NW'(FOCAL)) << FRAC;
    end

`ifdef PROJ_NEAR_CLIP_EN
    logic r_clip;
    assign w_clip = ($signed(r_z) <= NEAR);
    always_ff @(posedge clk_in) begin
        if (!rst_in)                r_clip <= 1'b0;
        else if (r_state == S_PREP) r_clip <= w_clip;
    end
    assign clip_out = r_clip;
`else
    assign w_clip   = 1'b0;
    assign clip_out = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (valid_in)    w_next = S_PREP;
            S_PREP:  w_next = w_clip ? S_DONE : S_DIV_X;
            S_DIV_X: if (w_step_done) w_next = S_DIV_Y;
            S_DIV_Y: if (w_step_done) w_next = S_DONE;
            S_DONE:  if (ready_in)    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // x starts straight from PREP's combinational numerator; y starts on
    // the same edge that captures the x quotient.
    always_comb begin
        ready_out   = (r_state == S_IDLE);
        w_step_done = w_div_done && !w_div_busy;
        w_start     = ((r_state == S_PREP) && !w_clip) ||
                      ((r_state == S_DIV_X) && w_step_done);
        w_dividend  = (r_state == S_PREP) ? w_num_x : r_num_y;
        w_divisor   = (r_state == S_PREP) ? NW'(w_az) : NW'(r_az);
    end

    fxp_div_seq #(.NW(NW)) u_div (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_start    (w_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_divisor),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );

    // A zero numerator must yield the bare offset even when z is zero.
    always_comb begin
        w_in_x = (r_state == S_DIV_X);
        w_neg  = w_in_x ? r_sx : r_sy;
        w_nz   = w_in_x ? (r_num_x == '0) : (r_num_y == '0);
        w_qmag = w_nz ? 64'sd0 : 64'(w_quo);
        w_qs   = w_neg ? -w_qmag : w_qmag;
        w_res  = WIDTH'(sat_add(w_qs, w_in_x ? c_off_x : c_off_y, WIDTH));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_az    <= '0;
            r_num_x <= '0;
            r_num_y <= '0;
            r_sx    <= 1'b0;
            r_sy    <= 1'b0;
            r_coor  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (valid_in) begin
                    r_x <= coor_in[2];
                    r_y <= coor_in[1];
                    r_z <= coor_in[0];
                end
                S_PREP: begin
                    r_num_x <= w_num_x;
                    r_num_y <= w_num_y;
                    r_az    <= w_az;
                    r_sx    <= r_x[WIDTH-1] ^ r_z[WIDTH-1];
                    r_sy    <= r_y[WIDTH-1] ^ r_z[WIDTH-1];
                    if (w_clip) begin
                        r_coor  <= '0;
                        r_valid <= 1'b1;
                    end
                end
                S_DIV_X: if (w_step_done) r_coor[1] <= w_res;
                S_DIV_Y: if (w_step_done) begin
                    r_coor[0] <= w_res;
                    r_valid   <= 1'b1;
                end
                S_DONE:  if (ready_in) r_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign coor_out  = r_coor;
    assign valid_out = r_valid;

endmodule
`default_nettype wire
